imem_loader: RTL

Writer side of the instruction-fetch memory. It replaces the fixed instruction ROM with a RAM that the fetch stage reads, plus a byte-stream load port that fills that RAM with a program. The CPU freeze line stays high while no program has been loaded or a load is in progress, so fetch only starts once the program is complete.

---
 rtl/imem_loader.sv | 208 ++++++++++++++++++++
 1 files changed

// File: rtl/imem_loader.sv
// Instruction RAM with a byte-stream program loader; holds the CPU frozen until a program is complete.
// Optional trailing checksum byte check enabled by defining IMEM_CHECKSUM_EN.
module imem_loader #(
    parameter int unsigned DEPTH     = 64,
    parameter int unsigned ADDR_W    = 6,
    parameter logic [31:0] BASE_ADDR = 32'd0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load_start,
    input  logic [ADDR_W:0]   load_len,
    input  logic              load_abort,
    input  logic              byte_valid,
    input  logic [7:0]        byte_data,
    output logic              byte_ready,
    input  logic [31:0]       PC,
    output logic [31:0]       inst,
    output logic              cpu_freeze,
    output logic              load_busy,
    output logic              load_done,
    output logic              load_err
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOAD   = 2'd1,
        FINISH = 2'd2
`ifdef IMEM_CHECKSUM_EN
        , CHECK = 2'd3
`endif
    } state_t;

    localparam logic [ADDR_W:0] DEPTH_W = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W:0] ONE_W   = (ADDR_W+1)'(1);

    state_t            state;
    state_t            state_nx;
    logic [1:0]        byte_cnt;
    logic [23:0]       asm_q;
    logic [ADDR_W:0]   len_q;
    logic [ADDR_W:0]   loaded_words;
    logic              freeze_q;
    logic              err_q;
    logic [31:0]       mem [DEPTH];

    logic              xfer;
    logic              len_ok;
    logic              word_wr;
    logic              last_word;
    logic [29:0]       rd_idx;
    logic              rd_hit;

`ifdef IMEM_CHECKSUM_EN
    logic [7:0]        sum_q;
    logic              chk_bad_q;
    logic              chk_ok_c;
    assign chk_ok_c = (8'(sum_q + byte_data) == 8'h00);
`endif

    assign xfer      = byte_valid & byte_ready;
    assign len_ok    = (load_len != '0) && (load_len <= DEPTH_W);
    assign word_wr   = (state == LOAD) && xfer && !load_abort && (byte_cnt == 2'd3);
    assign last_word = ((loaded_words + ONE_W) == len_q);

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state logic; abort wins over a byte arriving on the same edge
    always_comb begin
        state_nx = state;
        case (state)
            IDLE: begin
                if (load_start && len_ok) state_nx = LOAD;
            end
            LOAD: begin
                if (load_abort) begin
                    state_nx = IDLE;
                end else if (word_wr && last_word) begin
`ifdef IMEM_CHECKSUM_EN
                    state_nx = CHECK;
`else
                    state_nx = FINISH;
`endif
                end
            end
`ifdef IMEM_CHECKSUM_EN
            CHECK: begin
                if (load_abort) begin
                    state_nx = IDLE;
                end else if (xfer) begin
                    state_nx = FINISH;
                end
            end
`endif
            FINISH:  state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // State-decoded outputs
    always_comb begin
        byte_ready = 1'b0;
        load_busy  = 1'b0;
        load_done  = 1'b0;
        case (state)
            LOAD: begin
                byte_ready = 1'b1;
                load_busy  = 1'b1;
            end
`ifdef IMEM_CHECKSUM_EN
            CHECK: begin
                byte_ready = 1'b1;
                load_busy  = 1'b1;
            end
`endif
            FINISH:  load_done = 1'b1;
            default: ;
        endcase
    end

    // Byte assembly, word count, freeze and error flags
    always_ff @(posedge clk) begin
        if (rst) begin
            byte_cnt     <= 2'd0;
            asm_q        <= 24'd0;
            len_q        <= '0;
            loaded_words <= '0;
            freeze_q     <= 1'b1;
            err_q        <= 1'b0;
`ifdef IMEM_CHECKSUM_EN
            sum_q        <= 8'd0;
            chk_bad_q    <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (load_start) begin
                        if (len_ok) begin
                            byte_cnt     <= 2'd0;
                            len_q        <= load_len;
                            loaded_words <= '0;
                            freeze_q     <= 1'b1;
                            err_q        <= 1'b0;
`ifdef IMEM_CHECKSUM_EN
                            sum_q        <= 8'd0;
                            chk_bad_q    <= 1'b0;
`endif
                        end else begin
                            err_q <= 1'b1;
                        end
                    end
                end
                LOAD: begin
                    if (load_abort) begin
                        err_q <= 1'b1;
                    end else if (xfer) begin
                        byte_cnt <= byte_cnt + 2'd1;
`ifdef IMEM_CHECKSUM_EN
                        sum_q    <= 8'(sum_q + byte_data);
`endif
                        if (byte_cnt == 2'd3) begin
                            loaded_words <= loaded_words + ONE_W;
                        end else begin
                            asm_q[{byte_cnt, 3'b000} +: 8] <= byte_data;
                        end
                    end
                end
`ifdef IMEM_CHECKSUM_EN
                CHECK: begin
                    if (load_abort) begin
                        err_q <= 1'b1;
                    end else if (xfer && !chk_ok_c) begin
                        err_q        <= 1'b1;
                        loaded_words <= '0;
                        chk_bad_q    <= 1'b1;
                    end
                end
                FINISH: freeze_q <= chk_bad_q;
`else
                FINISH: freeze_q <= 1'b0;
`endif
                default: ;
            endcase
        end
    end

    // Instruction RAM write port (contents are not reset)
    always_ff @(posedge clk) begin
        if (word_wr) begin
            mem[loaded_words[ADDR_W-1:0]] <= {byte_data, asm_q};
        end
    end

    // Fetch read port, masked to the words of the current program
    assign rd_idx = 30'((PC - BASE_ADDR) >> 2);
    assign rd_hit = (PC >= BASE_ADDR) && (rd_idx < 30'(loaded_words));
    assign inst   = rd_hit ? mem[rd_idx[ADDR_W-1:0]] : 32'd0;

    assign cpu_freeze = freeze_q;
    assign load_err   = err_q;

endmodule
